muldiv_issue_ctrl: RTL and testbench

- EX-stage sequencer for the iterative M-extension unit (MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU).
- Detects an M-op in EX and latches its operands and op code.
- Fires a one-cycle start to the unit, freezes the pipeline until the unit's done pulse, and presents the result for exactly one cycle.
- Also handles flush-while-busy, a watchdog timeout and an optional result-reuse shortcut.

---
 rtl/muldiv_issue_ctrl_if.sv | 36 +++
 rtl/muldiv_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_issue_ctrl_if.sv
// Signal bundle between the EX stage, the M-extension issue controller and the iterative unit.
// master = pipeline/unit side, slave = issue controller.
interface muldiv_issue_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic [4:0]      ex_alu_ctrl;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic            flush;
  logic            mdu_mul_done;
  logic            mdu_div_done;
  logic [XLEN-1:0] mdu_result;
  logic            mdu_start;
  logic [4:0]      mdu_op;
  logic [XLEN-1:0] mdu_a;
  logic [XLEN-1:0] mdu_b;
  logic            stall;
  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic            timeout_err;

  modport master (
    output ex_valid, ex_alu_ctrl, ex_rs1, ex_rs2, flush,
    output mdu_mul_done, mdu_div_done, mdu_result,
    input  mdu_start, mdu_op, mdu_a, mdu_b,
    input  stall, res_valid, res_data, timeout_err
  );

  modport slave (
    input  ex_valid, ex_alu_ctrl, ex_rs1, ex_rs2, flush,
    input  mdu_mul_done, mdu_div_done, mdu_result,
    output mdu_start, mdu_op, mdu_a, mdu_b,
    output stall, res_valid, res_data, timeout_err
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage sequencer for the iterative MUL/DIV unit: latch, start, freeze, present result once.
// Optional result-reuse shortcut enabled by defining MULDIV_RESULT_REUSE_EN.
module muldiv_issue_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 80,
  parameter int unsigned CNT_W   = 8
) (
  input logic                clk,
  input logic                rst,
  muldiv_issue_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_start;
  logic            r_res_valid;
  logic            r_timeout;
  logic [4:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_res;

  logic            w_m_req;
  logic            w_done;
  logic            w_tmo;
  logic            w_reuse_hit;
  logic [XLEN-1:0] w_reuse_data;

  assign w_m_req = bus.ex_valid & bus.ex_alu_ctrl[4] & ~bus.flush;
  // Only the done pulse of the latched op's class (bit 2 = divide) counts.
  assign w_done  = r_op[2] ? bus.mdu_div_done : bus.mdu_mul_done;
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
    end else begin
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_m_req) begin
            r_op <= bus.ex_alu_ctrl;
            r_a  <= bus.ex_rs1;
            r_b  <= bus.ex_rs2;
            if (w_reuse_hit) begin
              r_res       <= w_reuse_data;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_start <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= bus.flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != CNT_W'(TIMEOUT)) r_cnt <= r_cnt + CNT_W'(1);
          // Flush beats a coincident done; the unit is idle again in that case.
          if (bus.flush) begin
            r_state <= w_done ? S_IDLE : S_DRAIN;
          end else if (w_done) begin
            r_res       <= bus.mdu_result;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_tmo) begin
            r_res       <= '0;
            r_res_valid <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_DRAIN: if (w_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MULDIV_RESULT_REUSE_EN
  logic            r_reuse_vld;
  logic [4:0]      r_reuse_op;
  logic [XLEN-1:0] r_reuse_a;
  logic [XLEN-1:0] r_reuse_b;
  logic [XLEN-1:0] r_reuse_res;

  // Remember the last operation that completed through the unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reuse_vld <= 1'b0;
      r_reuse_op  <= '0;
      r_reuse_a   <= '0;
      r_reuse_b   <= '0;
      r_reuse_res <= '0;
    end else if (r_state == S_WAIT && !bus.flush) begin
      if (w_done) begin
        r_reuse_vld <= 1'b1;
        r_reuse_op  <= r_op;
        r_reuse_a   <= r_a;
        r_reuse_b   <= r_b;
        r_reuse_res <= bus.mdu_result;
      end else if (w_tmo) begin
        r_reuse_vld <= 1'b0;
      end
    end
  end

  assign w_reuse_hit  = r_reuse_vld && (r_reuse_op == bus.ex_alu_ctrl) &&
                        (r_reuse_a == bus.ex_rs1) && (r_reuse_b == bus.ex_rs2);
  assign w_reuse_data = r_reuse_res;
`else
  assign w_reuse_hit  = 1'b0;
  assign w_reuse_data = '0;
`endif

  assign bus.mdu_start   = r_start;
  assign bus.mdu_op      = r_op;
  assign bus.mdu_a       = r_a;
  assign bus.mdu_b       = r_b;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res;
  assign bus.timeout_err = r_timeout;
  // Stall must rise in the same cycle the M-op appears, so it is decoded from state.
  assign bus.stall = rst & ((r_state == S_ISSUE) | (r_state == S_WAIT) |
                            (((r_state == S_IDLE) | (r_state == S_DRAIN)) & w_m_req));

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Randomized bench for muldiv_issue_ctrl: the bench plays pipeline and unit, results come from a
// reference M-extension model and timing expectations from the sequencing rules.
module tb_muldiv_issue_ctrl;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMEOUT = 80;

  localparam logic [4:0] OP_MUL  = 5'h10;
  localparam logic [4:0] OP_MULH = 5'h11;
  localparam logic [4:0] OP_DIV  = 5'h14;
  localparam logic [4:0] OP_DIVU = 5'h15;
  localparam logic [4:0] OP_REM  = 5'h16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_issue_ctrl_if #(.XLEN(XLEN)) bus ();

  muldiv_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics, including divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_m(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    r  = '0;
    case (op[2:0])
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'd0, b})); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 32'd0) ? '1 : (a == 32'h8000_0000 && b == '1) ? a : 32'(sa / sb);
      3'd5: r = (b == 32'd0) ? '1 : a / b;
      3'd6: r = (b == 32'd0) ? a : (a == 32'h8000_0000 && b == '1) ? 32'd0 : 32'(sa % sb);
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_opnd();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
    return $urandom();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.mdu_mul_done = 1'b0;
    bus.mdu_div_done = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic pulse(input logic div, input logic [31:0] res);
    if (div) bus.mdu_div_done = 1'b1;
    else     bus.mdu_mul_done = 1'b1;
    bus.mdu_result = res;
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.ex_valid    = v;
    bus.ex_alu_ctrl = op;
    bus.ex_rs1      = a;
    bus.ex_rs2      = b;
  endtask

  task automatic idle_cycle();
    step();
    bus.flush = 1'($urandom_range(0, 1));
    drive_ex(1'($urandom_range(0, 1)),
             bus.flush ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15)),
             $urandom(), $urandom());
    @(negedge clk);
    check("idle_stall", 32'(bus.stall), 32'd0);
    check("idle_start", 32'(bus.mdu_start), 32'd0);
    check("idle_res_valid", 32'(bus.res_valid), 32'd0);
  endtask

  // Normal op: stall from request through WAIT, start in cycle 1, result lat+2 cycles later.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int stray_at);
    logic [31:0] exp_res;
    exp_res = ref_m(op, a, b);
    step();
    drive_ex(1'b1, op, a, b);
    @(negedge clk);
    check("req_stall", 32'(bus.stall), 32'd1);
    check("req_start", 32'(bus.mdu_start), 32'd0);
    check("req_res_valid", 32'(bus.res_valid), 32'd0);
    step();
    @(negedge clk);
    check("issue_start", 32'(bus.mdu_start), 32'd1);
    check("issue_stall", 32'(bus.stall), 32'd1);
    check("issue_op", 32'(bus.mdu_op), 32'(op));
    check("issue_a", bus.mdu_a, a);
    check("issue_b", bus.mdu_b, b);
    for (int w = 1; w <= lat; w++) begin
      step();
      bus.ex_rs1 = $urandom();
      bus.ex_rs2 = $urandom();
      if (w == lat)           pulse(op[2], exp_res);
      else if (w == stray_at) pulse(!op[2], $urandom());
      @(negedge clk);
      check("wait_stall", 32'(bus.stall), 32'd1);
      check("wait_start", 32'(bus.mdu_start), 32'd0);
      check("wait_res_valid", 32'(bus.res_valid), 32'd0);
      check("wait_hold_a", bus.mdu_a, a);
      check("wait_hold_b", bus.mdu_b, b);
    end
    step();
    @(negedge clk);
    check("done_res_valid", 32'(bus.res_valid), 32'd1);
    check("done_res_data", bus.res_data, exp_res);
    check("done_stall", 32'(bus.stall), 32'd0);
    check("done_start", 32'(bus.mdu_start), 32'd0);
  endtask

  // Flush at WAIT cycle flush_w (0 = ISSUE cycle); the unit still finishes and is drained.
  task automatic run_drain(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int flush_w, input bit coincide, input int drain_cyc,
                           input bit present, input logic [4:0] nop, input logic [31:0] na,
                           input logic [31:0] nb);
    step();
    drive_ex(1'b1, op, a, b);
    @(negedge clk);
    check("dr_req_stall", 32'(bus.stall), 32'd1);
    for (int w = 0; w <= flush_w; w++) begin
      step();
      if (w == flush_w) begin
        bus.flush    = 1'b1;
        bus.ex_valid = 1'b0;
        if (coincide && w > 0) pulse(op[2], $urandom());
      end
      @(negedge clk);
      check("dr_busy_stall", 32'(bus.stall), 32'd1);
      check("dr_busy_start", 32'(bus.mdu_start), (w == 0) ? 32'd1 : 32'd0);
      check("dr_busy_res_valid", 32'(bus.res_valid), 32'd0);
    end
    if (coincide && flush_w > 0) return;
    for (int d = 1; d <= drain_cyc; d++) begin
      step();
      drive_ex(present, nop, na, nb);
      if (d == drain_cyc) pulse(op[2], $urandom());
      @(negedge clk);
      check("drain_stall", 32'(bus.stall), 32'(present));
      check("drain_start", 32'(bus.mdu_start), 32'd0);
      check("drain_res_valid", 32'(bus.res_valid), 32'd0);
    end
  endtask

  task automatic run_timeout(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    step();
    drive_ex(1'b1, op, a, b);
    @(negedge clk);
    check("to_req_stall", 32'(bus.stall), 32'd1);
    step();
    @(negedge clk);
    check("to_issue_start", 32'(bus.mdu_start), 32'd1);
    for (int w = 1; w <= int'(TIMEOUT); w++) begin
      step();
      @(negedge clk);
      check("to_wait_stall", 32'(bus.stall), 32'd1);
      check("to_wait_err", 32'(bus.timeout_err), 32'd0);
      check("to_wait_res_valid", 32'(bus.res_valid), 32'd0);
    end
    step();
    @(negedge clk);
    check("to_done_res_valid", 32'(bus.res_valid), 32'd1);
    check("to_done_res_data", bus.res_data, 32'd0);
    check("to_done_err", 32'(bus.timeout_err), 32'd1);
    check("to_done_stall", 32'(bus.stall), 32'd0);
    step();
    bus.ex_valid = 1'b0;
    pulse(1'b0, 32'hDEAD_BEEF);
    pulse(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("to_stray_stall", 32'(bus.stall), 32'd0);
    check("to_stray_res_valid", 32'(bus.res_valid), 32'd0);
    step();
    @(negedge clk);
    check("to_after_res_valid", 32'(bus.res_valid), 32'd0);
    check("to_after_start", 32'(bus.mdu_start), 32'd0);
    check("to_after_res_data", bus.res_data, 32'd0);
    check("to_sticky_err", 32'(bus.timeout_err), 32'd1);
  endtask

  task automatic run_reset_mid(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    step();
    drive_ex(1'b1, op, a, b);
    step();
    for (int w = 0; w < 3; w++) begin
      step();
      @(negedge clk);
      check("rm_wait_stall", 32'(bus.stall), 32'd1);
    end
    step();
    rst = 1'b0;
    #1;
    check("rm_start", 32'(bus.mdu_start), 32'd0);
    check("rm_op", 32'(bus.mdu_op), 32'd0);
    check("rm_a", bus.mdu_a, 32'd0);
    check("rm_b", bus.mdu_b, 32'd0);
    check("rm_stall", 32'(bus.stall), 32'd0);
    check("rm_res_valid", 32'(bus.res_valid), 32'd0);
    check("rm_res_data", bus.res_data, 32'd0);
    check("rm_err", 32'(bus.timeout_err), 32'd0);
    step();
    rst          = 1'b1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    check("rm_rel_stall", 32'(bus.stall), 32'd0);
    check("rm_rel_start", 32'(bus.mdu_start), 32'd0);
    check("rm_rel_res_valid", 32'(bus.res_valid), 32'd0);
  endtask

`ifdef MULDIV_RESULT_REUSE_EN
  task automatic run_reuse_hit(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    step();
    drive_ex(1'b1, op, a, b);
    @(negedge clk);
    check("ru_req_stall", 32'(bus.stall), 32'd1);
    check("ru_req_start", 32'(bus.mdu_start), 32'd0);
    step();
    @(negedge clk);
    check("ru_done_res_valid", 32'(bus.res_valid), 32'd1);
    check("ru_done_res_data", bus.res_data, ref_m(op, a, b));
    check("ru_done_stall", 32'(bus.stall), 32'd0);
    check("ru_done_start", 32'(bus.mdu_start), 32'd0);
    step();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    check("ru_after_start", 32'(bus.mdu_start), 32'd0);
    check("ru_after_res_valid", 32'(bus.res_valid), 32'd0);
  endtask
`endif

  initial begin
    logic [4:0]  op, nop;
    logic [31:0] a, b, na, nb;
    int          kind, lat, fw, da;
    bit          coin, pres;

    rst = 1'b0;
    drive_ex(1'b0, 5'd0, 32'd0, 32'd0);
    bus.flush        = 1'b0;
    bus.mdu_mul_done = 1'b0;
    bus.mdu_div_done = 1'b0;
    bus.mdu_result   = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_start", 32'(bus.mdu_start), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    check("rst_op", 32'(bus.mdu_op), 32'd0);
    check("rst_a", bus.mdu_a, 32'd0);
    check("rst_err", 32'(bus.timeout_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 6, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 12, 4);
    run_drain(OP_REM, 32'hFFFF_FFEF, 32'd5, 5, 1'b0, 4, 1'b1, OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 8, 0);
    run_timeout(OP_DIV, 32'd1000, 32'd3);
    run_reset_mid(OP_DIVU, 32'd9, 32'd2);
    run_op(OP_DIV, 32'd99, 32'hFFFF_FFFC, 10, 0);
`ifdef MULDIV_RESULT_REUSE_EN
    run_op(OP_DIV, 32'd50, 32'd5, 9, 0);
    run_reuse_hit(OP_DIV, 32'd50, 32'd5);
    run_op(OP_DIV, 32'd50, 32'd6, 9, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      op   = 5'h10 | 5'($urandom_range(0, 7));
      a    = rand_opnd();
      b    = rand_opnd();
      if (kind <= 6) begin
        lat = $urandom_range(1, 40);
        run_op(op, a, b, lat, $urandom_range(0, lat));
      end else if (kind <= 8) begin
        fw   = $urandom_range(0, 6);
        coin = (fw > 0) && ($urandom_range(0, 3) == 0);
        da   = $urandom_range(1, 8);
        pres = 1'($urandom_range(0, 1));
        nop  = 5'h10 | 5'($urandom_range(0, 7));
        na   = rand_opnd();
        nb   = rand_opnd();
        run_drain(op, a, b, fw, coin, da, pres, nop, na, nb);
        if (pres && !coin) run_op(nop, na, nb, $urandom_range(1, 20), 0);
      end else begin
        idle_cycle();
      end
    end

    step();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
